// File: rtl/memory_arbiter.sv
// Round-robin arbiter that gives REQUESTERS clients single-beat access to one
// main_memory control port. Each access takes IDLE -> ACCESS -> RESP, three cycles.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int REQUESTERS = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [REQUESTERS-1:0]         req,
   input  logic [REQUESTERS-1:0]         we,
   input  logic [ADDR_WIDTH-1:0]         addr [REQUESTERS],
   input  logic [DATA_WIDTH-1:0]         wdata [REQUESTERS],
   output logic [REQUESTERS-1:0]         ack,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [$clog2(REQUESTERS)-1:0] grant_id,
   output logic                          busy,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic                          mem_write,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic [1:0]                    dbg_state
);

   localparam int IDW = $clog2(REQUESTERS);

   // Handshake: a requester holds req (and its we/addr/wdata) stable until it
   // samples its ack bit high; ack is a one-cycle pulse and inputs are only
   // looked at while the FSM sits in IDLE.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t         state;
   logic [IDW-1:0] last_winner;
   logic           arb_found;
   logic [IDW-1:0] arb_winner;
   logic [IDW-1:0] cand;

   assign dbg_state = state;

   // Search starts one past the previous winner so every active requester is
   // served within REQUESTERS grants.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      cand       = '0;
      for (int i = 1; i <= REQUESTERS; i++) begin
         cand = IDW'((int'(last_winner) + i) % REQUESTERS);
         if (!arb_found && req[cand]) begin
            arb_found  = 1'b1;
            arb_winner = cand;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ack         <= '0;
         rdata       <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         last_winner <= IDW'(REQUESTERS - 1);
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (arb_found) begin
                  state     <= ACCESS;
                  busy      <= 1'b1;
                  grant_id  <= arb_winner;
                  mem_addr  <= addr[arb_winner];
                  mem_wdata <= wdata[arb_winner];
                  mem_write <= we[arb_winner];
               end
            end
            ACCESS: begin
               // mem_write still carries the latched we of this access here.
               state       <= RESP;
               mem_write   <= 1'b0;
               last_winner <= grant_id;
               ack         <= REQUESTERS'(1) << grant_id;
               if (!mem_write) begin
                  rdata <= mem_rdata;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               ack   <= '0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               ack       <= '0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

   a_write_only_in_access: assert property (
      @(posedge clock) disable iff (!reset_n) mem_write |-> (state == ACCESS));

   a_ack_onehot0: assert property (
      @(posedge clock) disable iff (!reset_n) $onehot0(ack));

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: two requesters, a behavioural main_memory
// and hand-computed expectations for grants, latency and read data.
module tb_memory_arbiter;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;

   logic       clock;
   logic       reset_n;
   logic [1:0] req;
   logic [1:0] we;
   logic [7:0] addr [2];
   logic [7:0] wdata [2];
   logic [1:0] ack;
   logic [7:0] rdata;
   logic [0:0] grant_id;
   logic       busy;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_write;
   logic [7:0] mem_rdata;
   logic [1:0] dbg_state;

   logic [7:0] mem [256];

   int tests_run    = 0;
   int tests_failed = 0;
   int ack_total    = 0;
   int model_lw     = 1;

   memory_arbiter #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(8),
      .REQUESTERS(2)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .grant_id  (grant_id),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole-run protocol monitor.
   always @(negedge clock) begin
      if (reset_n) begin
         check("mem_write_only_in_access", 32'(mem_write && (dbg_state != S_ACCESS)), 0);
         check("busy_low_in_idle", 32'(busy && (dbg_state == S_IDLE)), 0);
         check("ack_onehot0", 32'($countones(ack) > 1), 0);
         if (ack != 2'b00) ack_total++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(output logic [1:0] seen, output int cyc);
      bit done;
      done = 1'b0;
      seen = 2'b00;
      cyc  = 0;
      while (!done && cyc < 20) begin
         @(negedge clock);
         cyc++;
         if (ack != 2'b00) begin
            seen = ack;
            done = 1'b1;
         end
      end
      if (!done) check("ack_timeout", 0, 1);
   endtask

   // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
   task automatic single_access(input string tag, input int id, input logic w,
                                input logic [7:0] a, input logic [7:0] d);
      logic [1:0] seen;
      int         cyc;
      we[id]    = w;
      addr[id]  = a;
      wdata[id] = d;
      req[id]   = 1'b1;
      wait_ack(seen, cyc);
      check({tag, "_latency"}, cyc, 2);
      check({tag, "_ack"}, 32'(seen), 1 << id);
      check({tag, "_grant_id"}, 32'(grant_id), id);
      req[id] = 1'b0;
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req     = 2'b00;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ack"},       32'(ack), 0);
      check({tag, "_rdata"},     32'(rdata), 0);
      check({tag, "_grant_id"},  32'(grant_id), 0);
      check({tag, "_busy"},      32'(busy), 0);
      check({tag, "_mem_write"}, 32'(mem_write), 0);
      check({tag, "_mem_addr"},  32'(mem_addr), 0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      check({tag, "_state"},     32'(dbg_state), 32'(S_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] seen;
      int         cyc;
      int         exp_id;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[11] = 8'b0000_0101;
      reset_n  = 1'b0;
      req      = 2'b00;
      we       = 2'b00;
      addr[0]  = 8'h00;
      addr[1]  = 8'h00;
      wdata[0] = 8'h00;
      wdata[1] = 8'h00;

      // Reset values
      @(negedge clock);
      check_reset_values("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Write then read of addr 10
      single_access("wr10", 0, 1'b1, 8'd10, 8'b0101_0101);
      check("wr10_mem", 32'(mem[10]), 32'h55);
      check("wr10_rdata_unchanged", 32'(rdata), 0);
      single_access("rd10", 1, 1'b0, 8'd10, 8'h00);
      check("rd10_rdata", 32'(rdata), 32'h55);

      // A write leaves rdata alone
      single_access("rd11", 0, 1'b0, 8'd11, 8'h00);
      check("rd11_rdata", 32'(rdata), 32'h05);
      single_access("wr15", 0, 1'b1, 8'd15, 8'hFF);
      check("wr15_rdata_held", 32'(rdata), 32'h05);
      single_access("rd15", 1, 1'b0, 8'd15, 8'h00);
      check("rd15_rdata", 32'(rdata), 32'hFF);

      // Simultaneous requests right after reset: 0 wins, 1 follows 3 cycles later
      apply_reset();
      we       = 2'b00;
      addr[0]  = 8'd10;
      addr[1]  = 8'd11;
      req      = 2'b11;
      wait_ack(seen, cyc);
      check("sim_first_latency", cyc, 2);
      check("sim_first_ack", 32'(seen), 32'b01);
      check("sim_first_grant", 32'(grant_id), 0);
      check("sim_first_rdata", 32'(rdata), 32'h55);
      req[0] = 1'b0;
      wait_ack(seen, cyc);
      check("sim_second_gap", cyc, 3);
      check("sim_second_ack", 32'(seen), 32'b10);
      check("sim_second_grant", 32'(grant_id), 1);
      check("sim_second_rdata", 32'(rdata), 32'h05);
      req[1] = 1'b0;
      @(negedge clock);
      model_lw = 1;

      // Fairness: both requesters keep re-requesting
      req = 2'b11;
      for (int n = 0; n < 8; n++) begin
         wait_ack(seen, cyc);
         exp_id = (model_lw + 1) % 2;
         check("fair_ack", 32'(seen), 1 << exp_id);
         check("fair_grant", 32'(grant_id), exp_id);
         if (n > 0) check("fair_gap", cyc, 3);
         model_lw = exp_id;
      end
      req = 2'b00;
      @(negedge clock);

      // Reset in the middle of an access aborts it without an ack
      we[0]    = 1'b1;
      addr[0]  = 8'd20;
      wdata[0] = 8'hAA;
      req[0]   = 1'b1;
      @(negedge clock);
      check("midrst_in_access", 32'(dbg_state), 32'(S_ACCESS));
      check("midrst_busy", 32'(busy), 1);
      reset_n = 1'b0;
      req     = 2'b00;
      @(negedge clock);
      check_reset_values("midrst");
      @(negedge clock);
      check("midrst_no_ack", 32'(ack), 0);
      reset_n = 1'b1;
      single_access("rst_recover", 1, 1'b0, 8'd10, 8'h00);
      check("rst_recover_rdata", 32'(rdata), 32'h55);

      // A lone requester is granted even though it also won last time
      single_access("lone_req", 1, 1'b0, 8'd11, 8'h00);
      check("lone_req_rdata", 32'(rdata), 32'h05);

      // Accepted requests: 2 + 3 + 2 + 8 + 2, the aborted one gives none
      check("ack_total", ack_total, 17);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, memory data width.
REQ-003 Parameter REQUESTERS, default 2, number of requester ports (2..8).
REQ-004 Port clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port req[REQUESTERS]  input  1 each  access request; held high until the matching ack.
REQ-007 Port we[REQUESTERS]  input  1 each  1 = write, 0 = read.
REQ-008 Port addr[REQUESTERS]  input  ADDR_WIDTH each  access address.
REQ-009 Port wdata[REQUESTERS]  input  DATA_WIDTH each  write data.
REQ-010 Port ack[REQUESTERS]  output  1 each  one-cycle completion pulse.
REQ-011 Port rdata  output  DATA_WIDTH  registered read data, shared by all requesters.
REQ-012 Port grant_id  output  $clog2(REQUESTERS)  index of the current or last winner.
REQ-013 Port busy  output  1  high in ACCESS and RESP.
REQ-014 Port mem_addr  output  ADDR_WIDTH  drives both the read and write address of one main_memory control port.
REQ-015 Port mem_wdata  output  DATA_WIDTH  memory write data.
REQ-016 Port mem_write  output  1  memory write enable.
REQ-017 Port mem_rdata  input  DATA_WIDTH  combinational memory read data for mem_addr.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP, with transitions IDLE->ACCESS (any req high), ACCESS->RESP (always) and RESP->IDLE (always).
REQ-019 In IDLE with any req high, the block SHALL pick a winner round-robin, searching from last_winner+1 upward and wrapping modulo REQUESTERS.
REQ-020 On the IDLE->ACCESS edge, the block SHALL latch the winner's we, addr, wdata and index, and update grant_id.
REQ-021 In ACCESS, mem_addr, mem_wdata and mem_write SHALL be driven from the latched values; outside ACCESS, mem_write SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-022 On the ACCESS->RESP edge, rdata SHALL capture mem_rdata for a read; for a write, rdata SHALL hold its previous value.
REQ-023 In RESP, ack[grant_id] SHALL be 1 for exactly one cycle, and all other ack bits SHALL be 0.
REQ-024 On the ACCESS->RESP edge, last_winner SHALL be updated to grant_id.
REQ-025 Latency: with req sampled high in IDLE at edge k, the memory access SHALL occur in cycle k..k+1 (write committed at edge k+1) and ack SHALL be high in cycle k+1..k+2.
REQ-026 Throughput SHALL be at most one access per 3 cycles.
REQ-027 A requester SHALL deassert req, or present a new request, only after sampling ack high; the block SHALL ignore requester input changes while in ACCESS and RESP.
REQ-028 Simultaneous requests: exactly one requester SHALL be granted, and the others SHALL wait in IDLE arbitration on a later pass.
REQ-029 Starvation bound: a continuously asserted req SHALL be granted within REQUESTERS grants.
REQ-030 A single active requester SHALL be granted on every pass, regardless of last_winner.
REQ-031 A req that rises during ACCESS or RESP SHALL NOT be considered until the next IDLE cycle.

Reset
REQ-032 While reset_n is low, the state SHALL be IDLE, all ack bits 0, rdata 0, grant_id 0, busy 0, mem_write 0, mem_addr 0 and mem_wdata 0.
REQ-033 While reset_n is low, last_winner SHALL be REQUESTERS-1, so that requester 0 has first priority.
REQ-034 Reset asserted mid-operation SHALL abort the access with no ack.
REQ-035 If reset asserts during ACCESS, a write to memory MAY or MAY NOT have committed; the bench SHALL NOT check that location.
REQ-036 Deassertion of reset_n SHALL be followed by normal arbitration from the first rising clock edge.

Verification
REQ-037 Single write then read: req[0], we=1, addr=10, wdata=8'b01010101; after ack[0], req[1] reads addr=10 -> ack[1] 2 cycles after sampling, rdata=8'b01010101.
REQ-038 Simultaneous requests after reset: req[0] and req[1] high together -> ack[0] first, then ack[1] 3 cycles later; grant_id goes 0 then 1.
REQ-039 Fairness: both requesters continuously re-requesting for 8 accesses -> grants strictly alternate 0,1,0,1,...; at no time are two ack bits high together.
REQ-040 Write does not disturb rdata: read addr=11 returns 8'b00000101; a subsequent write of 8'hFF to addr=15 -> rdata still 8'b00000101; a read of addr=15 returns 8'hFF.
REQ-041 Mid-operation reset: reset_n pulsed low during ACCESS -> no ack, all outputs at reset values, and the next request from requester 1 alone is granted normally.
REQ-042 Protocol checks over the whole run: mem_write is high only in ACCESS; busy is 0 in IDLE; each accepted request produces exactly one ack.
